// File: rtl/calendar_pkg.sv
// Shared calendar datapath constants and the count-digit type.
package calendar_pkg;

  localparam int unsigned DIGIT_BITS    = 4;
  localparam int unsigned SEC_UNITS_MOD = 10;
  localparam int unsigned SEC_TENS_MOD  = 6;
  localparam int unsigned HOUR_TENS_MOD = 3;
  localparam int unsigned DAY_UNITS_MOD = 10;

  // One calendar digit, shared by the up and down counters.
  typedef logic [DIGIT_BITS-1:0] digit_t;

endpackage

// File: rtl/upcounter_if.sv
// Control and status bundle of one modulo counter stage.
interface upcounter_if
  import calendar_pkg::*;
#(
  parameter int unsigned BITS = DIGIT_BITS
) ();

  logic            en;
  logic            clr;
  logic            load;
  logic [BITS-1:0] load_val;
  logic [BITS-1:0] count;
  logic            carry;
  logic            wrap;
  logic            load_err;

  // Driver side: supplies controls, observes the count.
  modport master (
    output en, clr, load, load_val,
    input  count, carry, wrap, load_err
  );

  // Counter side.
  modport slave (
    input  en, clr, load, load_val,
    output count, carry, wrap, load_err
  );

endinterface

// File: rtl/upcounter.sv
// Modulo-MOD up counter with cascade carry, preset load and wrap/load-error pulses.
module upcounter
  import calendar_pkg::*;
#(
  parameter int unsigned MOD  = SEC_UNITS_MOD,
  parameter int unsigned BITS = DIGIT_BITS,
  parameter int unsigned INIT = 0
) (
  input  logic      clk,
  input  logic      rst,
  upcounter_if.slave bus
);

  localparam logic [BITS-1:0] LAST   = BITS'(MOD - 1);
  localparam logic [BITS-1:0] INIT_V = BITS'(INIT);

  // Reject moduli and reset values the counter cannot represent.
  if (MOD < 2 || 64'(MOD) > (64'd1 << BITS) || INIT >= MOD) begin : g_bad_params
    $fatal(1, "upcounter: illegal MOD/BITS/INIT combination");
  end

  logic [BITS-1:0] count_q;
  logic [BITS-1:0] count_d;
  logic            wrap_q;
  logic            wrap_d;
  logic            err_q;
  logic            err_d;
  logic            at_last;
  logic            lv_ok;

  // Terminal count compared at BITS width, so MOD == 2**BITS rolls over cleanly.
  assign at_last = (count_q == LAST);
  assign lv_ok   = (32'(bus.load_val) < MOD);

  // Same-cycle carry lets the next stage step on the very edge this one wraps.
  assign bus.carry = bus.en && at_last && !rst && !bus.clr && !bus.load;

  // Next-state selection, priority clr > load > en.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.clr) begin
      count_d = INIT_V;
    end else if (bus.load) begin
      if (lv_ok) begin
        count_d = bus.load_val;
      end else begin
        count_d = '0;
        err_d   = 1'b1;
      end
    end else if (bus.en) begin
      if (at_last) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + BITS'(1);
      end
    end
  end

  // State register with synchronous reset overriding every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= INIT_V;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;

endmodule

// File: doc/upcounter.md
Name: upcounter

Overview:
- Modulo-MOD up counter; the counting-up mirror of the calendar downcounter.
- Counts 0 to MOD-1, wraps to 0, and raises carry on the wrap edge.
- Built to be cascaded for calendar digits (seconds/minutes/hours/day units). A stage's carry drives the next stage's en; a load port presets the time/date.
- Sits alongside the downcounter in the calendar datapath and shares its clk/rst convention and carry semantics.

Parameters:
- MOD, 10, modulus; count sequence 0..MOD-1; legal range 2..2**BITS.
- BITS, 4, width of count and load_val.
- INIT, 0, value of count after reset and after clr; must be < MOD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count-enable; tie to the lower stage's carry when cascading, or to 1'b1 for the least-significant stage.
- clr  input  1  synchronous clear to INIT.
- load  input  1  synchronous preset strobe.
- load_val  input  BITS  preset value, sampled when load=1.
- count  output  BITS  current count (registered).
- carry  output  1  combinational cascade carry: en && count==MOD-1 && !rst && !clr && !load.
- wrap  output  1  registered one-cycle pulse, high the cycle after count wrapped MOD-1 -> 0.
- load_err  output  1  registered one-cycle pulse, high the cycle after a load with load_val >= MOD.

Behaviour:
- Reset (rst=1 at clock edge): count=INIT, wrap=0, load_err=0. carry=0 while rst=1. Reset mid-count overrides everything; no wrap pulse is produced.
- Priority per edge: rst > clr > load > en.
- clr=1: count<=INIT, wrap<=0, load_err<=0.
- load=1 and load_val<MOD: count<=load_val, wrap<=0, load_err<=0.
- load=1 and load_val>=MOD: count<=0 and load_err<=1 for exactly one cycle.
- en=1 (no clr/load):
  - count<MOD-1: count<=count+1, wrap<=0.
  - count==MOD-1: count<=0, wrap<=1.
- en=0: count holds; wrap<=0; load_err<=0.
- Latency:
  - count changes 1 cycle after an enabled edge.
  - carry is same-cycle combinational, so a cascaded next stage increments on the same edge the current stage wraps. No ripple delay accumulates across stages.
  - wrap lags carry by exactly 1 cycle.
- Width rules:
  - Compare against MOD-1 at BITS width; no arithmetic overflow beyond BITS.
  - When MOD==2**BITS, the wrap is the natural rollover and must still flag wrap/carry.
- Simultaneous load+en at count==MOD-1: load wins; carry=0 and wrap=0.
- count is never outside 0..MOD-1 in any reachable state.
- Elaboration check: MOD<2, MOD>2**BITS or INIT>=MOD is a fatal error at elaboration.

Decomposition:
- Shared package calendar_pkg holds:
  - digit moduli constants: SEC_UNITS_MOD=10, SEC_TENS_MOD=6, HOUR_TENS_MOD=3, DAY_UNITS_MOD=10;
  - DIGIT_BITS=4;
  - the count-digit typedef, shared with the downcounter.
- No sub-module. The terminal-count compare is a single line; a helper would add nothing.
- A two-stage cascade wrapper (upcounter_chain) is a separate later block, not part of this one.

Test Plan:
- Reset/count-up (MOD=10, en=1): hold rst 2 cycles, release. count=0 after reset, then 1,2,…,9,0. carry=1 only while count=9. wrap=1 in the cycle count shows 0 after 9; wrap=0 elsewhere.
- Enable gating: en toggles 1,0,1,0 from count=3. count goes 4,4,5,5. With count=9 and en=0, carry=0 and count holds at 9.
- Load:
  - load=1, load_val=7: next count=7, load_err=0.
  - load=1, load_val=12: next count=0, load_err=1 for one cycle, then 0.
  - load at count=9 with en=1: count=load_val, wrap stays 0.
- Priority/mid-op reset:
  - At count=9 with en=1, assert clr: count=INIT, no wrap.
  - At count=5, assert rst with load=1, load_val=2: count=0, load_err=0, carry=0.
- Cascade (two instances, MOD=10 units, MOD=6 tens; units carry -> tens en), run 60 enabled cycles from 00. Tens increments on the same edge units goes 9->0. Count reaches 59 then 00. Tens wrap pulses exactly once, at the 60th edge.
- Full-range modulus (MOD=16, BITS=4): count 0..15, then 0. carry=1 at count=15; wrap pulses after rollover; no X/overflow.
